// File: rtl/test_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : test_pattern_gen
//  Description : Multi-mode video test-pattern source. It sits between the
//                video timing generator and the YUV-to-composite modulator.
//                Modes: colour bars (75%/100%), luma ramp, checkerboard and
//                solid colour. An optional per-frame horizontal scroll is
//                available. All outputs are registered.
//  Ports       : clk, rst          - pixel clock, synchronous active-high reset
//                newline/newframe  - one-cycle line / frame start pulses
//                newpixel          - pixel enable strobe
//                video_y           - current line number
//                visible_window    - high during the active picture
//                mode/full_amp/scroll_en/solid_sel - pattern controls,
//                                    taken into effect at each newframe
//                luma, yuv_u, yuv_v - Y (unsigned), U/V (signed) outputs
//                out_valid         - visible_window delayed to match the data
//  Revision    : 1.0 - initial release
// ============================================================================
module test_pattern_gen #(
    parameter int PIXEL_W       = 9,
    parameter int BAR_SHIFT     = 5,
    parameter int ACTIVE_PIXELS = 256,
    parameter int CHECK_SHIFT   = 4,
    parameter int SCROLL_STEP   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              newline,
    input  logic              newframe,
    input  logic              newpixel,
    input  logic [8:0]        video_y,
    input  logic              visible_window,
    input  logic [1:0]        mode,
    input  logic              full_amp,
    input  logic              scroll_en,
    input  logic [2:0]        solid_sel,
    output logic [7:0]        luma,
    output logic signed [7:0] yuv_u,
    output logic signed [7:0] yuv_v,
    output logic              out_valid
);

    localparam logic [1:0] c_MODE_BARS  = 2'd0;
    localparam logic [1:0] c_MODE_RAMP  = 2'd1;
    localparam logic [1:0] c_MODE_CHECK = 2'd2;
    localparam logic [1:0] c_MODE_SOLID = 2'd3;

    // One bit wider than the pixel counter so ACTIVE_PIXELS = 2^PIXEL_W fits.
    localparam logic [PIXEL_W:0]   c_ACTIVE_LIM = (PIXEL_W+1)'(ACTIVE_PIXELS);
    localparam logic [PIXEL_W-1:0] c_STEP       = PIXEL_W'(SCROLL_STEP);

    // Bar tables packed as {Y, U, V}; U and V are two's complement.
    function automatic logic [23:0] bar75(input logic [2:0] idx);
        logic [23:0] r_val;
        case (idx)
            3'd0:    r_val = {8'd255, 8'(0),   8'(0)};
            3'd1:    r_val = {8'd168, 8'(-41), 8'(9)};
            3'd2:    r_val = {8'd133, 8'(14),  8'(-58)};
            3'd3:    r_val = {8'd112, 8'(-27), 8'(-49)};
            3'd4:    r_val = {8'd76,  8'(27),  8'(49)};
            3'd5:    r_val = {8'd56,  8'(-14), 8'(58)};
            3'd6:    r_val = {8'd20,  8'(41),  8'(-9)};
            default: r_val = {8'd0,   8'(0),   8'(0)};
        endcase
        return r_val;
    endfunction

    function automatic logic [23:0] bar100(input logic [2:0] idx);
        logic [23:0] r_val;
        case (idx)
            3'd0:    r_val = {8'd255, 8'(0),   8'(0)};
            3'd1:    r_val = {8'd224, 8'(-55), 8'(12)};
            3'd2:    r_val = {8'd177, 8'(19),  8'(-77)};
            3'd3:    r_val = {8'd149, 8'(-36), 8'(-65)};
            3'd4:    r_val = {8'd101, 8'(36),  8'(65)};
            3'd5:    r_val = {8'd75,  8'(-19), 8'(77)};
            3'd6:    r_val = {8'd27,  8'(55),  8'(-12)};
            default: r_val = {8'd0,   8'(0),   8'(0)};
        endcase
        return r_val;
    endfunction

    logic [PIXEL_W-1:0] r_pixel_x;
    logic [PIXEL_W-1:0] r_offset;
    logic [1:0]         r_mode;
    logic               r_full_amp;
    logic               r_scroll_en;
    logic [2:0]         r_solid_sel;

    // ---------------------------------------------------------------- counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixel_x   <= '0;
            r_offset    <= '0;
            r_mode      <= c_MODE_BARS;
            r_full_amp  <= 1'b0;
            r_scroll_en <= 1'b0;
            r_solid_sel <= 3'd0;
        end else begin
            // Clear has priority over a coincident strobe; count saturates.
            if (newline) begin
                r_pixel_x <= '0;
            end else if (visible_window && newpixel && (r_pixel_x != '1)) begin
                r_pixel_x <= r_pixel_x + 1'b1;
            end

            // The scroll enable being latched at this frame start decides
            // whether this frame is shifted; offset wraps naturally.
            if (newframe) begin
                if (scroll_en) begin
                    r_offset <= r_offset + c_STEP;
                end
                r_mode      <= mode;
                r_full_amp  <= full_amp;
                r_scroll_en <= scroll_en;
                r_solid_sel <= solid_sel;
            end
        end
    end

    // ---------------------------------------------------------- pattern logic
    logic [PIXEL_W-1:0] w_xs;
    logic [2:0]         w_bar_idx;
    logic [23:0]        w_bar;
    logic [23:0]        w_solid;
    logic               w_cell;
    logic               w_beyond;
    logic [7:0]         w_y;
    logic [7:0]         w_u;
    logic [7:0]         w_v;

    assign w_xs      = r_pixel_x + r_offset;
    assign w_bar_idx = w_xs[BAR_SHIFT +: 3];
    assign w_bar     = r_full_amp ? bar100(w_bar_idx)   : bar75(w_bar_idx);
    assign w_solid   = r_full_amp ? bar100(r_solid_sel) : bar75(r_solid_sel);
    assign w_cell    = w_xs[CHECK_SHIFT] ^ video_y[CHECK_SHIFT];
    // Active-width blanking uses the unscrolled position.
    assign w_beyond  = ({1'b0, r_pixel_x} >= c_ACTIVE_LIM);

    always_comb begin
        w_y = 8'd0;
        w_u = 8'd0;
        w_v = 8'd0;
        if (visible_window && !w_beyond) begin
            case (r_mode)
                c_MODE_BARS: begin
                    {w_y, w_u, w_v} = w_bar;
                end
                c_MODE_RAMP: begin
                    w_y = w_xs[7:0];
                end
                c_MODE_CHECK: begin
                    w_y = w_cell ? 8'd0 : (r_full_amp ? 8'd255 : 8'd191);
                end
                c_MODE_SOLID: begin
                    {w_y, w_u, w_v} = w_solid;
                end
                default: begin
                    w_y = 8'd0;
                end
            endcase
        end
    end

    // Latched scroll enable is kept for visibility of frame state only.
    logic w_unused;
    assign w_unused = ^{video_y, w_xs, r_scroll_en};

    // ---------------------------------------------------------- output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            luma      <= 8'd0;
            yuv_u     <= 8'sd0;
            yuv_v     <= 8'sd0;
            out_valid <= 1'b0;
        end else begin
            luma      <= w_y;
            yuv_u     <= w_u;
            yuv_v     <= w_v;
            out_valid <= visible_window;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_test_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_test_pattern_gen
//  Description : Self-checking bench for test_pattern_gen. A behavioural
//                model computes every expected output with plain arithmetic
//                on pixel position, scroll offset and bar tables.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_test_pattern_gen;

    localparam int c_ACTIVE = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              newline;
    logic              newframe;
    logic              newpixel;
    logic [8:0]        video_y;
    logic              visible_window;
    logic [1:0]        mode;
    logic              full_amp;
    logic              scroll_en;
    logic [2:0]        solid_sel;
    logic [7:0]        luma;
    logic signed [7:0] yuv_u;
    logic signed [7:0] yuv_v;
    logic              out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference colour bars, [amplitude][index]: 0 = 75%, 1 = 100%.
    int bar_y [2][8] = '{'{255, 168, 133, 112,  76,  56,  20, 0},
                         '{255, 224, 177, 149, 101,  75,  27, 0}};
    int bar_u [2][8] = '{'{  0, -41,  14, -27,  27, -14,  41, 0},
                         '{  0, -55,  19, -36,  36, -19,  55, 0}};
    int bar_v [2][8] = '{'{  0,   9, -58, -49,  49,  58,  -9, 0},
                         '{  0,  12, -77, -65,  65,  77, -12, 0}};

    // Model state
    int m_px, m_off, m_mode, m_fa, m_ss;
    int last_px;
    bit last_act;

    test_pattern_gen #(
        .PIXEL_W       (9),
        .BAR_SHIFT     (5),
        .ACTIVE_PIXELS (c_ACTIVE),
        .CHECK_SHIFT   (4),
        .SCROLL_STEP   (2)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .newline        (newline),
        .newframe       (newframe),
        .newpixel       (newpixel),
        .video_y        (video_y),
        .visible_window (visible_window),
        .mode           (mode),
        .full_amp       (full_amp),
        .scroll_en      (scroll_en),
        .solid_sel      (solid_sel),
        .luma           (luma),
        .yuv_u          (yuv_u),
        .yuv_v          (yuv_v),
        .out_valid      (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: predict output from pre-edge model state and inputs,
    // advance the model, then compare after the edge.
    task automatic tick();
        int ey, eu, ev, evalid, xs, idx;
        ey = 0; eu = 0; ev = 0;
        if (!rst && visible_window && m_px < c_ACTIVE) begin
            xs = (m_px + m_off) % 512;
            case (m_mode)
                0: begin
                    idx = (xs / 32) % 8;
                    ey = bar_y[m_fa][idx]; eu = bar_u[m_fa][idx]; ev = bar_v[m_fa][idx];
                end
                1: ey = xs % 256;
                2: ey = ((((xs / 16) % 2) ^ ((int'(video_y) / 16) % 2)) != 0) ? 0
                        : (m_fa != 0 ? 255 : 191);
                default: begin
                    ey = bar_y[m_fa][m_ss]; eu = bar_u[m_fa][m_ss]; ev = bar_v[m_fa][m_ss];
                end
            endcase
        end
        evalid   = (!rst && visible_window) ? 1 : 0;
        last_px  = m_px;
        last_act = visible_window && !rst;
        @(posedge clk);
        if (rst) begin
            m_px = 0; m_off = 0; m_mode = 0; m_fa = 0; m_ss = 0;
        end else begin
            if (newline) m_px = 0;
            else if (visible_window && newpixel && m_px < 511) m_px++;
            if (newframe) begin
                if (scroll_en) m_off = (m_off + 2) % 512;
                m_mode = int'(mode);
                m_fa   = int'(full_amp);
                m_ss   = int'(solid_sel);
            end
        end
        #1;
        check("luma",      luma,      ey);
        check("yuv_u",     yuv_u,     eu);
        check("yuv_v",     yuv_v,     ev);
        check("out_valid", out_valid, evalid);
    endtask

    // Frame start coincident with a line start.
    task automatic frame();
        newframe = 1'b1; newline = 1'b1; visible_window = 1'b0; newpixel = 1'b0;
        tick();
        newframe = 1'b0; newline = 1'b0;
    endtask

    // One line of nvis visible cycles; optionally spot-check the output
    // produced by pixel 'probe' against fixed expected values.
    task automatic run_line(input int vy, input int nvis, input int probe,
                            input string tag, input int py, input int pu,
                            input int pv, input bit rnd);
        bit seen;
        seen = 1'b0;
        video_y = 9'(vy);
        newline = 1'b1; visible_window = 1'b0; newpixel = 1'b1;
        tick();
        newline = 1'b0;
        for (int i = 0; i < nvis; i++) begin
            visible_window = 1'b1;
            newpixel = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            if (probe >= 0 && !seen && last_act && last_px == probe) begin
                seen = 1'b1;
                check({tag, "_y"}, luma,  py);
                check({tag, "_u"}, yuv_u, pu);
                check({tag, "_v"}, yuv_v, pv);
            end
        end
        if (probe >= 0) check({tag, "_seen"}, seen, 1);
        visible_window = 1'b0; newpixel = 1'b0;
        tick();
        tick();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; newline = 1'b0; newframe = 1'b0; newpixel = 1'b0;
        video_y = '0; visible_window = 1'b0; mode = 2'd0; full_amp = 1'b0;
        scroll_en = 1'b0; solid_sel = 3'd0;
        m_px = 0; m_off = 0; m_mode = 0; m_fa = 0; m_ss = 0;
        tick();
        tick();
        check("reset_luma",  luma,      0);
        check("reset_valid", out_valid, 0);
        rst = 1'b0;

        // Bars at 75%, reset-default shadows
        run_line(0, 256, 40,  "bar75_p40",  168, -41, 9, 0);
        run_line(0, 256, 255, "bar75_p255", 0, 0, 0, 0);

        // out_valid lags visible_window by one cycle
        newline = 1'b1; tick(); newline = 1'b0;
        visible_window = 1'b1; newpixel = 1'b1;
        check("valid_lag_pre", out_valid, 0);
        tick();
        check("valid_lag_post", out_valid, 1);
        visible_window = 1'b0; newpixel = 1'b0; tick();
        check("valid_lag_fall", out_valid, 0);

        // full_amp change takes effect only at the next frame
        full_amp = 1'b1;
        run_line(1, 256, 100, "amp_midframe", 112, -27, -49, 0);
        frame();
        run_line(0, 256, 100, "amp_100", 149, -36, -65, 0);

        // Ramp with scroll: three frames -> offset 6
        mode = 2'd1; scroll_en = 1'b1;
        frame(); frame(); frame();
        run_line(0, 256, 10,  "ramp_p10",  16, 0, 0, 0);
        run_line(0, 256, 250, "ramp_p250", 0, 0, 0, 0);
        scroll_en = 1'b0;
        frame();
        run_line(0, 256, 10, "ramp_hold", 16, 0, 0, 0);
        // Long line: counter must saturate rather than wrap into active range
        run_line(0, 530, -1, "sat", 0, 0, 0, 0);

        // Checkerboard at 75%
        reset_pulse();
        mode = 2'd2; full_amp = 1'b0;
        frame();
        run_line(0,  320, 0,   "chk_l0p0",   191, 0, 0, 0);
        run_line(0,  320, 16,  "chk_l0p16",  0,   0, 0, 0);
        run_line(16, 320, 16,  "chk_l16p16", 191, 0, 0, 0);
        run_line(16, 320, 300, "chk_p300",   0,   0, 0, 0);

        // Solid colour
        mode = 2'd3; solid_sel = 3'd5; full_amp = 1'b1;
        frame();
        run_line(5, 256, 77, "solid_p77", 75, -19, 77, 0);
        check("solid_blank", luma, 0);

        // newline coincident with newpixel: clear wins
        mode = 2'd1; scroll_en = 1'b0;
        frame();
        newline = 1'b1; tick(); newline = 1'b0;
        visible_window = 1'b1; newpixel = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        newline = 1'b1; tick(); newline = 1'b0;
        newpixel = 1'b0; tick();
        check("nl_np_clear", luma, 0);

        // Reset mid-line
        newpixel = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_mid_luma", luma, 0);
        check("rst_mid_u",    yuv_u, 0);
        visible_window = 1'b0; newpixel = 1'b0; tick();
        run_line(0, 256, 40, "post_rst_bars", 168, -41, 9, 0);

        // Randomized frames with mid-frame control changes and reset pulses
        for (int f = 0; f < 12; f++) begin
            mode = 2'($urandom_range(0, 3)); full_amp = 1'($urandom_range(0, 1));
            scroll_en = 1'($urandom_range(0, 1)); solid_sel = 3'($urandom_range(0, 7));
            frame();
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(0, 2) == 0) begin
                    mode = 2'($urandom_range(0, 3)); full_amp = 1'($urandom_range(0, 1));
                    solid_sel = 3'($urandom_range(0, 7));
                end
                if ($urandom_range(0, 15) == 0) reset_pulse();
                run_line(int'($urandom_range(0, 511)), int'($urandom_range(200, 330)),
                         -1, "rnd", 0, 0, 0, 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
